data_mem_lsu: RTL

- Parametrised successor to the team's single-port 32-bit data RAM.
- Adds RISC-V load/store sizing (byte/half/word, plus double when D_WIDTH=64), byte-lane write enables, and sign/zero extension.
- Adds a valid/ready request handshake, a registered one-cycle response, misalignment/range fault reporting, and a post-reset zero-fill sequencer.
- Sits in the MEM stage of the pipeline; the storage array is inferred RAM, with no vendor primitive.

---
 rtl/data_mem_lsu.sv | 132 +++++++++++++
 1 files changed

// File: rtl/data_mem_lsu.sv
// MEM-stage load/store unit over an inferred RAM, with RISC-V sizing, byte lanes, sign/zero extension and fault reporting.
// One-cycle registered response; req_ready stays low during post-reset zero-fill, then accepts one request every cycle.
module data_mem_lsu #(
  parameter int D_WIDTH   = 32,
  parameter int A_WIDTH   = 8,
  parameter bit INIT_ZERO = 1'b1
) (
  input  logic               clock,
  input  logic               rst_n,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_we,
  input  logic [2:0]         req_funct3,
  input  logic [D_WIDTH-1:0] req_addr,
  input  logic [D_WIDTH-1:0] req_wdata,
  output logic               rsp_valid,
  output logic [D_WIDTH-1:0] rsp_rdata,
  output logic               rsp_fault,
  output logic               init_done
);

  localparam int NB    = D_WIDTH / 8;
  localparam int L     = $clog2(NB);
  localparam int DEPTH = 1 << A_WIDTH;
  localparam bit IS64  = (D_WIDTH == 64);

  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t             state;
  logic [A_WIDTH-1:0] cnt;
  logic [D_WIDTH-1:0] mem [DEPTH];

  logic [A_WIDTH-1:0] idx;
  logic [L-1:0]       off;
  logic [2:0]         off3;
  logic               upper_bad, misal, f3_bad, fault;
  logic [7:0]         size_mask;
  logic [NB-1:0]      be;
  logic [D_WIDTH-1:0] wlane, rd_word, shifted, ld_data;
  logic               accept, st_we, fill_we;

  assign idx  = req_addr[A_WIDTH+L-1:L];
  assign off  = req_addr[L-1:0];
  assign off3 = 3'(off);

  always_comb begin
    upper_bad = (req_addr >> (A_WIDTH + L)) != '0;
    case (req_funct3[1:0])
      2'd1:    misal = off3[0];
      2'd2:    misal = |off3[1:0];
      2'd3:    misal = |off3;
      default: misal = 1'b0;
    endcase
    if (req_we)
      f3_bad = !((req_funct3 inside {3'b000, 3'b001, 3'b010}) ||
                 (IS64 && req_funct3 == 3'b011));
    else
      f3_bad = !((req_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101}) ||
                 (IS64 && (req_funct3 inside {3'b011, 3'b110})));
    fault = upper_bad | misal | f3_bad;
  end

  // Accesses are naturally aligned, so shifting right-aligned data by the offset places every lane.
  always_comb begin
    case (req_funct3[1:0])
      2'd0:    size_mask = 8'h01;
      2'd1:    size_mask = 8'h03;
      2'd2:    size_mask = 8'h0F;
      default: size_mask = 8'hFF;
    endcase
    be    = NB'(size_mask) << off;
    wlane = req_wdata << {off, 3'b000};
  end

  assign accept  = rst_n && req_valid && req_ready;
  assign st_we   = accept && req_we && !fault;
  assign fill_we = rst_n && (state == S_INIT) && INIT_ZERO;

  always_ff @(posedge clock) begin
    if (fill_we)
      mem[cnt] <= '0;
    else if (st_we)
      for (int b = 0; b < NB; b++)
        if (be[b]) mem[idx][8*b +: 8] <= wlane[8*b +: 8];
  end

  // Asynchronous read so a store at N is visible to a load accepted at N+1.
  always_comb begin
    rd_word = mem[idx];
    shifted = rd_word >> {off, 3'b000};
    case (req_funct3)
      3'b000:  ld_data = D_WIDTH'($signed(shifted[7:0]));
      3'b100:  ld_data = D_WIDTH'(shifted[7:0]);
      3'b001:  ld_data = D_WIDTH'($signed(shifted[15:0]));
      3'b101:  ld_data = D_WIDTH'(shifted[15:0]);
      3'b010:  ld_data = D_WIDTH'($signed(shifted[31:0]));
      3'b110:  ld_data = D_WIDTH'(shifted[31:0]);
      default: ld_data = shifted;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!rst_n) begin
      state     <= S_INIT;
      cnt       <= '0;
      req_ready <= 1'b0;
      init_done <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_fault <= 1'b0;
    end else begin
      rsp_valid <= accept;
      if (accept) begin
        rsp_fault <= fault;
        rsp_rdata <= (fault || req_we) ? '0 : ld_data;
      end
      case (state)
        S_INIT: begin
          if (!INIT_ZERO || (&cnt)) begin
            state     <= S_RUN;
            req_ready <= 1'b1;
            init_done <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
